// File: rtl/fpu_uart_pkg.sv
// Shared constants and FSM state encoding for the UART-fed FPU controller.
// Operands arrive from a UART byte buffer; the result is streamed back LSB byte first.
package fpu_uart_pkg;

  localparam int DEF_SIZE_DATA = 32;
  localparam int DEF_SIZE_BYTE = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAP_A    = 3'd1,
    WAIT_B   = 3'd2,
    CAP_B    = 3'd3,
    LAUNCH   = 3'd4,
    WAIT_RES = 3'd5,
    SEND     = 3'd6
  } state_t;

endpackage

// File: rtl/fpu_uart_edge_det.sv
// Rising-edge detector for the two operand-ready levels.
// A rise is reported in the same cycle the level first reads high.
module fpu_uart_edge_det (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] done,
  output logic [1:0] rise
);

  logic [1:0] prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= 2'b00;
    else        prev_reg <= done;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rise
    assign rise[gi] = done[gi] & ~prev_reg[gi];
  end

endmodule

// File: rtl/fpu_uart_ctrl.sv
// Captures two operands, launches the FPU, waits (bounded) for its result and
// streams the result to the UART transmitter one byte at a time.
module fpu_uart_ctrl
  import fpu_uart_pkg::*;
#(
  parameter int SIZE_DATA   = DEF_SIZE_DATA,
  parameter int SIZE_BYTE   = DEF_SIZE_BYTE,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_done_a,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic                 i_done_b,
  input  logic [SIZE_DATA-1:0] i_data_b,
  output logic                 o_fpu_start,
  output logic [SIZE_DATA-1:0] o_fpu_a,
  output logic [SIZE_DATA-1:0] o_fpu_b,
  input  logic                 i_fpu_valid,
  input  logic [SIZE_DATA-1:0] i_fpu_result,
  output logic                 o_tx_valid,
  output logic [SIZE_BYTE-1:0] o_tx_data,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_err_timeout
);

  localparam int NUM_BYTES = SIZE_DATA / SIZE_BYTE;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t               state_reg;
  logic [SIZE_DATA-1:0] a_reg;
  logic [SIZE_DATA-1:0] b_reg;
  logic [SIZE_DATA-1:0] result_reg;
  logic                 start_reg;
  logic                 err_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [1:0]           rise;
  logic [SIZE_BYTE-1:0] result_bytes [NUM_BYTES];

  fpu_uart_edge_det u_edge_det (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .done  ({i_done_b, i_done_a}),
    .rise  (rise)
  );

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
    assign result_bytes[gi] = result_reg[gi*SIZE_BYTE +: SIZE_BYTE];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      start_reg  <= 1'b0;
      err_reg    <= 1'b0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // done_b alone (or together with done_a) never starts a transaction
          if (rise[0]) state_reg <= CAP_A;
        end
        CAP_A: begin
          a_reg     <= i_data_a;
          err_reg   <= 1'b0;
          state_reg <= WAIT_B;
        end
        WAIT_B: begin
          if (rise[0])      state_reg <= CAP_A;
          else if (rise[1]) state_reg <= CAP_B;
        end
        CAP_B: begin
          b_reg     <= i_data_b;
          state_reg <= LAUNCH;
        end
        LAUNCH: begin
          start_reg <= 1'b1;
          cnt_reg   <= '0;
          state_reg <= WAIT_RES;
        end
        WAIT_RES: begin
          if (i_fpu_valid) begin
            result_reg <= i_fpu_result;
            idx_reg    <= '0;
            state_reg  <= SEND;
          end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        SEND: begin
          if (i_tx_ready) begin
            if (idx_reg == IDX_W'(NUM_BYTES - 1)) state_reg <= IDLE;
            else                                  idx_reg   <= idx_reg + IDX_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // TX outputs decode straight from state so reset removes them without a clock
  assign o_tx_valid    = (state_reg == SEND);
  assign o_tx_data     = (state_reg == SEND) ? result_bytes[idx_reg] : '0;
  assign o_busy        = (state_reg != IDLE);
  assign o_fpu_start   = start_reg;
  assign o_fpu_a       = a_reg;
  assign o_fpu_b       = b_reg;
  assign o_err_timeout = err_reg;

endmodule

// File: tb/tb_fpu_uart_ctrl.sv
// Directed bench for fpu_uart_ctrl: stimulus pushes expected launches and TX
// bytes into queues; a forked monitor pops and compares as the DUT presents them.
module tb_fpu_uart_ctrl;

  localparam int T = 32;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_done_a = 1'b0;
  logic [31:0] i_data_a = '0;
  logic        i_done_b = 1'b0;
  logic [31:0] i_data_b = '0;
  logic        o_fpu_start;
  logic [31:0] o_fpu_a;
  logic [31:0] o_fpu_b;
  logic        i_fpu_valid = 1'b0;
  logic [31:0] i_fpu_result = '0;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready = 1'b1;
  logic        o_busy;
  logic        o_err_timeout;

  int total = 0;
  int bad = 0;

  logic [63:0] exp_start [$];
  logic [7:0]  exp_tx [$];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [7:0]  prev_data = '0;
  int          early_err;

  always #5 i_clk = ~i_clk;

  fpu_uart_ctrl #(.SIZE_DATA(32), .SIZE_BYTE(8), .TIMEOUT_CYC(T)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_done_a      (i_done_a),
    .i_data_a      (i_data_a),
    .i_done_b      (i_done_b),
    .i_data_b      (i_data_b),
    .o_fpu_start   (o_fpu_start),
    .o_fpu_a       (o_fpu_a),
    .o_fpu_b       (o_fpu_b),
    .i_fpu_valid   (i_fpu_valid),
    .i_fpu_result  (i_fpu_result),
    .o_tx_valid    (o_tx_valid),
    .o_tx_data     (o_tx_data),
    .i_tx_ready    (i_tx_ready),
    .o_busy        (o_busy),
    .o_err_timeout (o_err_timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic pulse_a(input logic [31:0] d);
    @(negedge i_clk);
    i_data_a = d;
    i_done_a = 1'b1;
    @(negedge i_clk);
    i_done_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] d);
    @(negedge i_clk);
    i_data_b = d;
    i_done_b = 1'b1;
    @(negedge i_clk);
    i_done_b = 1'b0;
  endtask

  task automatic give_result(input logic [31:0] r);
    @(negedge i_clk);
    i_fpu_result = r;
    i_fpu_valid  = 1'b1;
    @(negedge i_clk);
    i_fpu_valid  = 1'b0;
  endtask

  task automatic push_bytes(input logic [31:0] r);
    for (int k = 0; k < 4; k++) exp_tx.push_back(r[k*8 +: 8]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, o_fpu_start, 0);
    check({tag, "_txv"}, o_tx_valid, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_err"}, o_err_timeout, 0);
    check({tag, "_a"}, o_fpu_a, 0);
    check({tag, "_b"}, o_fpu_b, 0);
    check({tag, "_txd"}, o_tx_data, 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge i_clk);
        #1;
        if (o_fpu_start) begin
          if (exp_start.size() == 0) check("start_unexpected", 1, 0);
          else check("start_ab", {o_fpu_a, o_fpu_b}, exp_start.pop_front());
        end
        if (o_tx_valid && prev_valid && !prev_ready)
          check("tx_stall_stable", o_tx_data, prev_data);
        if (o_tx_valid && i_tx_ready) begin
          if (exp_tx.size() == 0) check("tx_unexpected", o_tx_data, 0);
          else check("tx_byte", o_tx_data, exp_tx.pop_front());
        end
        prev_valid = o_tx_valid;
        prev_ready = i_tx_ready;
        prev_data  = o_tx_data;
      end
    join_none

    // Reset state
    #2;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Basic launch with start-pulse timing relative to CAP_B entry
    pulse_a(32'h3F800000);
    @(negedge i_clk);
    check("cap_a", o_fpu_a, 32'h3F800000);
    check("busy_wait_b", o_busy, 1);
    exp_start.push_back({32'h3F800000, 32'h40000000});
    @(negedge i_clk);
    i_data_b = 32'h40000000;
    i_done_b = 1'b1;
    @(posedge i_clk); #1;
    check("start_at_capb", o_fpu_start, 0);
    @(negedge i_clk);
    i_done_b = 1'b0;
    @(posedge i_clk); #1;
    check("start_at_launch", o_fpu_start, 0);
    @(posedge i_clk); #1;
    check("start_pulse", o_fpu_start, 1);
    check("launch_b", o_fpu_b, 32'h40000000);
    @(posedge i_clk); #1;
    check("start_one_cycle", o_fpu_start, 0);

    // Result streamed with ready held high: four consecutive bytes
    push_bytes(32'h40400000);
    give_result(32'h40400000);
    for (int k = 0; k < 4; k++) begin
      check("tx_consecutive", o_tx_valid, 1);
      @(negedge i_clk);
    end
    check("tx_done_valid", o_tx_valid, 0);
    check("tx_done_idle", o_busy, 0);

    // Alternating ready stalls
    exp_start.push_back({32'h40A00000, 32'h3F000000});
    pulse_a(32'h40A00000);
    pulse_b(32'h3F000000);
    repeat (2) @(negedge i_clk);
    push_bytes(32'hC1D2E3F4);
    i_tx_ready = 1'b0;
    give_result(32'hC1D2E3F4);
    repeat (16) begin
      @(negedge i_clk);
      i_tx_ready = ~i_tx_ready;
    end
    i_tx_ready = 1'b1;
    check("stall_idle", o_busy, 0);
    check("stall_all_bytes", exp_tx.size(), 0);

    // FPU timeout
    exp_start.push_back({32'h00000001, 32'h00000002});
    pulse_a(32'h00000001);
    pulse_b(32'h00000002);
    @(posedge i_clk);
    @(posedge i_clk);
    early_err = 0;
    for (int k = 1; k <= T; k++) begin
      @(posedge i_clk); #1;
      if (k < T && o_err_timeout) early_err++;
    end
    check("timeout_early", early_err, 0);
    check("timeout_flag", o_err_timeout, 1);
    check("timeout_idle", o_busy, 0);

    // Stray FPU valid in IDLE must not start a transfer
    give_result(32'hDEADBEEF);
    repeat (3) @(negedge i_clk);
    check("stray_valid_idle", o_busy, 0);
    check("timeout_sticky", o_err_timeout, 1);

    // Flag clears at the next CAP_A
    pulse_a(32'h3F800000);
    check("err_in_cap_a", o_err_timeout, 1);
    @(negedge i_clk);
    check("err_cleared", o_err_timeout, 0);

    // Second done_a rise in WAIT_B recaptures A
    pulse_a(32'h12345678);
    @(negedge i_clk);
    check("recapture_a", o_fpu_a, 32'h12345678);
    exp_start.push_back({32'h12345678, 32'h0BADF00D});
    pulse_b(32'h0BADF00D);
    repeat (3) @(negedge i_clk);
    push_bytes(32'hA1B2C3D4);
    give_result(32'hA1B2C3D4);
    repeat (6) @(negedge i_clk);
    check("recapture_idle", o_busy, 0);

    // Simultaneous rises in IDLE capture only A
    @(negedge i_clk);
    i_data_a = 32'h55AA55AA;
    i_data_b = 32'h99999999;
    i_done_a = 1'b1;
    i_done_b = 1'b1;
    @(negedge i_clk);
    i_done_a = 1'b0;
    i_done_b = 1'b0;
    @(negedge i_clk);
    check("simul_a", o_fpu_a, 32'h55AA55AA);
    repeat (3) @(negedge i_clk);
    check("simul_b_kept", o_fpu_b, 32'h0BADF00D);
    check("simul_wait_b", o_busy, 1);

    // Reset during SEND after two bytes
    exp_start.push_back({32'h55AA55AA, 32'hCAFEBABE});
    pulse_b(32'hCAFEBABE);
    repeat (2) @(negedge i_clk);
    push_bytes(32'h01020304);
    give_result(32'h01020304);
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    check("abort_pending", exp_tx.size(), 2);
    exp_tx.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Full sequence after the abort
    exp_start.push_back({32'h3F800000, 32'h40000000});
    pulse_a(32'h3F800000);
    pulse_b(32'h40000000);
    repeat (3) @(negedge i_clk);
    push_bytes(32'h40400000);
    give_result(32'h40400000);
    repeat (6) @(negedge i_clk);
    check("post_reset_idle", o_busy, 0);
    check("start_queue_empty", exp_start.size(), 0);
    check("tx_queue_empty", exp_tx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_uart_ctrl.md
FPU_UART_CTRL -- requirements
Module: fpu_uart_ctrl

Interface
REQ-001 The block SHALL have parameter SIZE_DATA, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter SIZE_BYTE, default 8, meaning UART TX byte width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning maximum cycles waited for an FPU result.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset:
  i_clk  input  1  clock, all state on rising edge
  i_rst_n  input  1  asynchronous active-low reset
REQ-005 The block SHALL have these ports:
  i_done_a  input  1  operand-A-ready level from the UART byte buffer
  i_data_a  input  SIZE_DATA  operand A, valid one cycle after i_done_a rises
  i_done_b  input  1  operand-B-ready level
  i_data_b  input  SIZE_DATA  operand B, valid one cycle after i_done_b rises
  o_fpu_start  output  1  one-cycle FPU launch pulse
  o_fpu_a  output  SIZE_DATA  captured operand A
  o_fpu_b  output  SIZE_DATA  captured operand B
  i_fpu_valid  input  1  result-valid pulse from the FPU
  i_fpu_result  input  SIZE_DATA  FPU result, sampled when i_fpu_valid=1
  o_tx_valid  output  1  TX byte valid
  o_tx_data  output  SIZE_BYTE  TX byte
  i_tx_ready  input  1  TX accepts the byte when o_tx_valid&i_tx_ready
  o_busy  output  1  high in every state except IDLE
  o_err_timeout  output  1  sticky FPU-timeout flag

Function
REQ-006 The block SHALL register i_done_a and i_done_b and act only on rising edges (current=1, previous=0).
REQ-007 The FSM SHALL have states IDLE, CAP_A, WAIT_B, CAP_B, LAUNCH, WAIT_RES and SEND.
REQ-008 IDLE SHALL go to CAP_A on a rise of done_a; a rise of done_b in IDLE is ignored, including a simultaneous rise.
REQ-009 CAP_A SHALL load o_fpu_a from i_data_a, clear o_err_timeout and go to WAIT_B in one cycle.
REQ-010 WAIT_B SHALL go to CAP_B on a rise of done_b; a rise of done_a in WAIT_B returns to CAP_A and recaptures A.
REQ-011 CAP_B SHALL load o_fpu_b from i_data_b and go to LAUNCH.
REQ-012 LAUNCH SHALL assert o_fpu_start for exactly one cycle and go to WAIT_RES; o_fpu_a and o_fpu_b stay stable from capture until the next CAP_A/CAP_B.
REQ-013 WAIT_RES SHALL latch i_fpu_result when i_fpu_valid=1, clear the byte index to 0 and go to SEND.
REQ-014 In WAIT_RES, a counter starting at 0 SHALL count each cycle without i_fpu_valid. On reaching TIMEOUT_CYC-1 with no valid, the block sets o_err_timeout and goes to IDLE with no TX.
REQ-015 i_fpu_valid outside WAIT_RES SHALL be ignored.
REQ-016 SEND SHALL hold o_tx_valid=1 with o_tx_data = result byte[index], LSB byte first.
REQ-017 In SEND, the index SHALL advance only on o_tx_valid&i_tx_ready; o_tx_data stays stable while stalled.
REQ-018 The acceptance of byte SIZE_DATA/SIZE_BYTE-1 SHALL return the FSM to IDLE, with o_tx_valid low the next cycle.
REQ-019 Rises of done_a or done_b during LAUNCH, WAIT_RES and SEND SHALL be ignored and not queued.
REQ-020 o_tx_valid SHALL be 0 in every state except SEND.

Reset
REQ-021 Asserting i_rst_n low SHALL immediately force state IDLE, and at any time, including mid-SEND, it aborts the transfer.
REQ-022 Reset SHALL force the following to 0: o_fpu_start, o_tx_valid, o_busy, o_err_timeout, o_fpu_a, o_fpu_b, o_tx_data, the result latch, the edge registers and the counters.

Structure
REQ-023 The state enum and the default SIZE_DATA/SIZE_BYTE constants SHALL reside in the shared package fpu_uart_pkg.
REQ-024 The block SHALL contain a single sub-module, fpu_uart_edge_det, which detects rising edges on the two done inputs; all else is flat.

Verification
REQ-025 The bench SHALL run this sequence: done_a rise with A=0x3F800000, then done_b rise with B=0x40000000. Required: o_fpu_start pulses once, two cycles after CAP_B entry, with a=0x3F800000 and b=0x40000000.
REQ-026 The bench SHALL return result 0x40400000 with i_tx_ready=1 held. Required: TX bytes 0x00,0x00,0x40,0x40 on 4 consecutive cycles, then IDLE.
REQ-027 The bench SHALL toggle i_tx_ready 0/1 alternately during SEND. Required: each byte stays stable while stalled, no byte is duplicated and no byte is skipped.
REQ-028 The bench SHALL withhold i_fpu_valid. Required: o_err_timeout rises TIMEOUT_CYC cycles after WAIT_RES entry, o_tx_valid never asserts, and the flag clears on the next CAP_A.
REQ-029 The bench SHALL cover two boundaries. First, a second done_a rise in WAIT_B with A=0x12345678 makes o_fpu_a=0x12345678. Second, simultaneous done_a/done_b rises in IDLE capture only A.
REQ-030 The bench SHALL assert reset during SEND after 2 bytes. Required: o_tx_valid drops asynchronously, all outputs read 0, and the next full sequence works.
